// File: rtl/zoom_line_window_pkg.sv
// Shared defaults and the per-pixel sideband that travels alongside the RAM read.
package zoom_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 11;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_RD_LATENCY = 2;

  typedef struct packed {
    logic                      valid;
    logic                      first_row;
    logic [DEF_ADDR_WIDTH-1:0] col;
    logic [DEF_DATA_WIDTH-1:0] data;
  } pix_sb_t;

endpackage

// File: rtl/zoom_line_window_if.sv
// Port bundle between the line-window controller and the single-port line RAM.
interface zoom_line_window_if #(
  parameter int unsigned ADDR_WIDTH = zoom_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = zoom_pkg::DEF_DATA_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (output ram_addr, output ram_wr_data, output ram_wr_en, input ram_rd_data);
  modport slave  (input ram_addr, input ram_wr_data, input ram_wr_en, output ram_rd_data);

endinterface

// File: rtl/zoom_line_window_dly_line.sv
// N-stage shift register carrying the pixel sideband across the RAM read path.
module zoom_dly_line
  import zoom_pkg::*;
#(
  parameter int unsigned N = DEF_RD_LATENCY
) (
  input  logic    clk,
  input  logic    tb_rst,
  input  pix_sb_t d_i,
  output pix_sb_t q_o
);

  pix_sb_t stage_q [N];

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      for (int unsigned i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/zoom_line_window.sv
// Line-buffer controller: writes each pixel to the line RAM, reads back the previous
// row at the same column, and emits an aligned 2x2 window to the interpolator.
module zoom_line_window
  import zoom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  zoom_line_window_if.master    ram,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_cur,
  output logic [DATA_WIDTH-1:0] m_cur_d,
  output logic [DATA_WIDTH-1:0] m_prev,
  output logic [DATA_WIDTH-1:0] m_prev_d,
  output logic [ADDR_WIDTH-1:0] m_col,
  output logic                  m_first_row,
  output logic                  err_ovf
);

  localparam logic [ADDR_WIDTH-1:0] COL_MAX = '1;

  logic [ADDR_WIDTH-1:0] col_q, col_d, eff_col;
  logic                  first_row_q, first_row_d, row_flag;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  pix_sb_t               pix_q, pix_d, win;
  logic [DATA_WIDTH-1:0] prev_px;

  always_comb begin
    eff_col     = s_sof ? '0 : col_q;
    row_flag    = s_sof | first_row_q;
    col_d       = col_q;
    first_row_d = first_row_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    pix_d       = '0;
    if (s_valid) begin
      addr_d          = eff_col;
      wdata_d         = s_data;
      we_d            = 1'b1;
      pix_d.valid     = 1'b1;
      pix_d.first_row = row_flag;
      pix_d.col       = eff_col;
      pix_d.data      = s_data;
      first_row_d     = s_eol ? 1'b0 : row_flag;
      if (s_sof) err_d = 1'b0;
      // A full line without s_eol pins the column at the last address.
      if (s_eol) begin
        col_d = '0;
      end else if (eff_col == COL_MAX) begin
        col_d = COL_MAX;
        err_d = 1'b1;
      end else begin
        col_d = eff_col + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      col_q       <= '0;
      first_row_q <= 1'b1;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      pix_q       <= '0;
    end else begin
      col_q       <= col_d;
      first_row_q <= first_row_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      pix_q       <= pix_d;
    end
  end

  assign ram.ram_addr    = addr_q;
  assign ram.ram_wr_data = wdata_q;
  assign ram.ram_wr_en   = we_q;
  assign err_ovf         = err_q;

  // pix_q sits level with the ram_* registers, so N=RD_LATENCY more stages line up with ram_rd_data.
  zoom_dly_line #(.N(RD_LATENCY)) u_dly (
    .clk    (clk),
    .tb_rst (tb_rst),
    .d_i    (pix_q),
    .q_o    (win)
  );

  assign prev_px = win.first_row ? '0 : ram.ram_rd_data;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      m_valid     <= 1'b0;
      m_cur       <= '0;
      m_cur_d     <= '0;
      m_prev      <= '0;
      m_prev_d    <= '0;
      m_col       <= '0;
      m_first_row <= 1'b0;
    end else begin
      m_valid <= win.valid;
      if (win.valid) begin
        m_cur       <= win.data;
        m_prev      <= prev_px;
        m_cur_d     <= (win.col == '0) ? win.data : m_cur;
        m_prev_d    <= (win.col == '0) ? prev_px : m_prev;
        m_col       <= win.col;
        m_first_row <= win.first_row;
      end
    end
  end

endmodule

// File: tb/tb_zoom_line_window.sv
// Directed bench for zoom_line_window with a read-before-write line RAM model.
module tb_zoom_line_window;

  logic        clk;
  logic        tb_rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_sof;
  logic        s_eol;
  logic        m_valid;
  logic [15:0] m_cur, m_cur_d, m_prev, m_prev_d;
  logic [10:0] m_col;
  logic        m_first_row;
  logic        err_ovf;

  int compared   = 0;
  int mismatched = 0;

  zoom_line_window_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) ram_if ();

  zoom_line_window #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .RD_LATENCY(2)) dut (
    .clk         (clk),
    .tb_rst      (tb_rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_eol       (s_eol),
    .ram         (ram_if),
    .m_valid     (m_valid),
    .m_cur       (m_cur),
    .m_cur_d     (m_cur_d),
    .m_prev      (m_prev),
    .m_prev_d    (m_prev_d),
    .m_col       (m_col),
    .m_first_row (m_first_row),
    .err_ovf     (err_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 2048x16 line RAM: address sampled one edge after the controller registers it,
  // old content returned one edge later.
  logic [15:0] mem [2048];
  logic [15:0] rd_stage;
  initial for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
  always @(posedge clk) begin
    if (ram_if.ram_wr_en) mem[ram_if.ram_addr] <= ram_if.ram_wr_data;
    rd_stage           <= mem[ram_if.ram_addr];
    ram_if.ram_rd_data <= rd_stage;
  end

  // Expected window for pixel p of the two-row frame {1,2,3,4 / 5,6,7,8}; index 0 = reset state.
  int unsigned t_cur  [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
  int unsigned t_curd [9] = '{0, 1, 1, 2, 3, 5, 5, 6, 7};
  int unsigned t_prev [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 4};
  int unsigned t_prevd[9] = '{0, 0, 0, 0, 0, 1, 1, 2, 3};
  int unsigned t_col  [9] = '{0, 0, 1, 2, 3, 0, 1, 2, 3};
  int unsigned t_fr   [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

  int unsigned hold_idx   = 0;
  bit          hold_known = 1'b1;
  int unsigned exp_addr   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_window();
    chk("m_cur",       32'(m_cur),       t_cur[hold_idx]);
    chk("m_cur_d",     32'(m_cur_d),     t_curd[hold_idx]);
    chk("m_prev",      32'(m_prev),      t_prev[hold_idx]);
    chk("m_prev_d",    32'(m_prev_d),    t_prevd[hold_idx]);
    chk("m_col",       32'(m_col),       t_col[hold_idx]);
    chk("m_first_row", 32'(m_first_row), t_fr[hold_idx]);
  endtask

  task automatic run_frame(input int gap, input int npix, input int drain);
    int nsteps;
    int p;
    bit vin, vout;
    nsteps = (npix - 1) * gap + 1 + drain;
    for (int j = 0; j < nsteps; j++) begin
      vin     = ((j % gap) == 0) && ((j / gap) < npix);
      p       = j / gap + 1;
      s_valid = vin;
      s_data  = vin ? 16'(p) : 16'h0;
      s_sof   = vin && (p == 1);
      s_eol   = vin && (p == 4 || p == 8);
      step();
      if (vin) begin
        exp_addr = (p - 1) % 4;
        chk("ram_wr_data", 32'(ram_if.ram_wr_data), p);
      end
      chk("ram_wr_en", 32'(ram_if.ram_wr_en), 32'(vin));
      chk("ram_addr",  32'(ram_if.ram_addr),  exp_addr);
      chk("err_ovf",   32'(err_ovf),          0);
      vout = (j >= 3) && (((j - 3) % gap) == 0) && (((j - 3) / gap) < npix);
      if (vout) begin
        hold_idx   = (j - 3) / gap + 1;
        hold_known = 1'b1;
      end
      chk("m_valid", 32'(m_valid), 32'(vout));
      if (hold_known) chk_window();
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    s_data  = 16'h0;
  endtask

  initial begin
    tb_rst  = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'h0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    #100;
    chk("rst_m_valid",   32'(m_valid),          0);
    chk("rst_ram_wr_en", 32'(ram_if.ram_wr_en), 0);
    chk("rst_ram_addr",  32'(ram_if.ram_addr),  0);
    chk("rst_err_ovf",   32'(err_ovf),          0);
    chk_window();
    #100;
    tb_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_m_valid",   32'(m_valid),          0);
      chk("idle_ram_wr_en", 32'(ram_if.ram_wr_en), 0);
    end

    // Back-to-back two-line frame, then the same frame with every-other-cycle input.
    run_frame(1, 8, 3);
    run_frame(2, 8, 3);

    // 2049 pixels in one line: the column saturates at 2047 and err_ovf latches.
    s_valid = 1'b1;
    s_eol   = 1'b0;
    for (int k = 1; k <= 2049; k++) begin
      s_data = 16'(k);
      s_sof  = (k == 1);
      step();
      if (k == 1)    chk("ovf_start_addr", 32'(ram_if.ram_addr), 0);
      if (k == 2047) begin
        chk("ovf_err_2047",  32'(err_ovf),          0);
        chk("ovf_addr_2047", 32'(ram_if.ram_addr),  2046);
      end
      if (k >= 2048) begin
        chk("ovf_err",  32'(err_ovf),         1);
        chk("ovf_addr", 32'(ram_if.ram_addr), 2047);
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_idle_we",   32'(ram_if.ram_wr_en), 0);
      chk("ovf_idle_addr", 32'(ram_if.ram_addr),  2047);
      chk("ovf_idle_err",  32'(err_ovf),          1);
    end
    exp_addr   = 2047;
    hold_known = 1'b0;

    // The next s_sof clears err_ovf and restarts at address 0; stop at column 1 of row 1.
    run_frame(1, 6, 0);

    tb_rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid),          0);
    chk("midrst_m_cur",   32'(m_cur),            0);
    chk("midrst_m_prev",  32'(m_prev),           0);
    chk("midrst_m_col",   32'(m_col),            0);
    chk("midrst_we",      32'(ram_if.ram_wr_en), 0);
    chk("midrst_addr",    32'(ram_if.ram_addr),  0);
    step();
    step();
    tb_rst     = 1'b0;
    hold_idx   = 0;
    hold_known = 1'b1;
    exp_addr   = 0;
    step();
    chk("postrst_m_valid", 32'(m_valid), 0);

    // Fresh frame after reset: row 0 must report first_row with zeroed previous row.
    run_frame(1, 8, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/zoom_line_window.md
# zoom_line_window

Line-buffer controller for the ZOOM scaler. It sits directly upstream of the 2048×16 single-port line RAM (read-before-write, registered output) and drives that RAM's address, write data and write enable. For each incoming pixel it writes the pixel into the RAM and reads back the previous line's pixel at the same column in the same access. It then emits an aligned 2×2 pixel window (current and previous row, current and left column) to the bilinear interpolation stage downstream.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width; maximum line length is 2^ADDR_WIDTH pixels.
- DATA_WIDTH, 16, pixel and RAM data width.
- RD_LATENCY, 2, cycles from the RAM sampling an address to ram_rd_data being valid.

Ports:
- clk  in  1  clock; RAM shares this clock.
- tb_rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input pixel valid; no backpressure, gaps allowed.
- s_data  in  DATA_WIDTH  input pixel.
- s_sof  in  1  qualifies the first pixel of a frame (valid only with s_valid).
- s_eol  in  1  qualifies the last pixel of a line (valid only with s_valid).
- ram_addr  out  ADDR_WIDTH  RAM address (registered).
- ram_wr_data  out  DATA_WIDTH  RAM write data (registered).
- ram_wr_en  out  1  RAM write enable (registered).
- ram_rd_data  in  DATA_WIDTH  RAM read data; returns the old content of the address.
- m_valid  out  1  window valid.
- m_cur, m_cur_d  out  DATA_WIDTH each  current-row pixel at column c and at column c-1.
- m_prev, m_prev_d  out  DATA_WIDTH each  previous-row pixel at column c and at column c-1.
- m_col  out  ADDR_WIDTH  column c of the window.
- m_first_row  out  1  window belongs to row 0 of the frame.
- err_ovf  out  1  sticky line-overflow flag.

## Operation
- Column counter col:
  - On each accepted pixel, the registers load ram_addr=col, ram_wr_data=s_data, ram_wr_en=1.
  - col then increments.
  - After a pixel with s_eol, col returns to 0.
  - A pixel with s_sof is forced to column 0, regardless of the current col value.
- Idle cycle (s_valid=0): ram_wr_en=0; ram_addr and ram_wr_data hold.
- Row flag first_row:
  - Set by s_sof; it applies to the s_sof pixel itself.
  - Cleared after the first s_eol that follows.
  - Applied to the pixel it travels with.
  - While first_row=1, m_prev and m_prev_d are forced to 0 (the RAM still holds the previous frame's data).
- Alignment: the pixel, col, first_row and valid bit pass through a delay line matched to the RAM read path. ram_rd_data is paired with the pixel whose address produced it.
- Window:
  - m_cur_d and m_prev_d take the previous valid window's m_cur and m_prev.
  - At column 0 they replicate m_cur and m_prev (edge replication).
- Overflow:
  - If col=2^ADDR_WIDTH-1 and the pixel is not s_eol, col saturates and err_ovf sets.
  - Further pixels overwrite the last address.
  - err_ovf clears only on s_sof or reset.
- Read-before-write guarantees that the read at column c returns the line-(n-1) pixel even though line n writes the same address in the same cycle.

## Timing
- Reset values:
  - All outputs 0.
  - col=0, first_row=1, delay lines cleared.
- Latency:
  - A pixel sampled at edge t drives the ram_* registers after t; the RAM samples them at edge t+1.
  - ram_rd_data is valid after edge t+RD_LATENCY.
  - The m_* outputs register it at edge t+RD_LATENCY+1. The fixed latency is RD_LATENCY+1 = 3 cycles.
- m_valid reproduces the s_valid pattern exactly, delayed by 3 cycles. Sustained throughput is 1 pixel/clk.
- m_* values hold while m_valid=0.
- s_sof and s_eol on the same pixel means a one-pixel line: column 0, first_row set and then cleared for the next line.
- Reset mid-line: outputs drop to 0 immediately. Pipeline contents are discarded; RAM contents are untouched.

## Structure
- Package zoom_pkg: ADDR_WIDTH, DATA_WIDTH and RD_LATENCY defaults, plus a packed struct of the per-pixel sideband {valid, first_row, col, data}.
- Sub-module zoom_dly_line: a parametric N-stage shift register with asynchronous reset, carrying the sideband struct. It is instantiated once with N=RD_LATENCY.

## Test plan
- Reset: hold tb_rst for 200 ns, then release -> all outputs 0, ram_wr_en 0, no activity until the first s_valid.
- Two 4-pixel lines (rows 1,2,3,4 / 5,6,7,8), s_sof on pixel 1, s_eol on pixels 4 and 8, bench RAM model 2048×16 read-before-write with RAM latency 2:
  - ram_addr sequence is 0,1,2,3,0,1,2,3.
  - Row 0 gives m_cur=1..4 with m_prev=0.
  - Row 1 gives m_cur=5..8 with m_prev=1..4.
  - Each m_valid arrives 3 cycles after its input.
- Window check on row 1:
  - At col 1: m_cur=6, m_cur_d=5, m_prev=2, m_prev_d=1.
  - At col 0: m_cur_d=5, m_prev_d=1 (replicated).
- Gapped input, s_valid every other cycle, same data -> identical window values; m_valid alternates, delayed by 3 cycles.
- 2049 pixels without s_eol:
  - err_ovf=1 from the 2048th pixel onward.
  - ram_addr holds 2047.
  - The next s_sof clears err_ovf and restarts at addr 0.
- Assert tb_rst at col 2 of row 1 -> outputs 0 immediately; the following s_sof frame has m_first_row=1 and m_prev=0 on row 0.
